// File: rtl/pri_enc_16_4.sv
// pri_enc_16_4: registered 16-to-4 priority encoder with pending store and valid/ack handshake
module pri_enc_16_4 #(
  parameter bit RR_EN = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [15:0] req,
  input  logic        ack,
  output logic [3:0]  idx,
  output logic        valid,
  output logic [15:0] pend,
  output logic        overrun
);
  logic [15:0] req_q, rise, clr, p_next;
  logic [3:0] last, base, sel, j;
  always_comb begin
    rise = req & ~req_q & {16{en}};
    clr = (valid && ack) ? 16'(1) << idx : '0;
    p_next = (pend & ~clr) | rise;
    base = (valid && ack) ? idx : last;
    sel = '0;
    j = '0;
    for (int i = 0; i < 16; i++) begin
      j = RR_EN ? base + 4'd1 + 4'(15 - i) : 4'(i);
      if (p_next[j]) sel = j;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      req_q <= '0;
      pend <= '0;
      idx <= '0;
      valid <= 1'b0;
      last <= 4'd15;
      overrun <= 1'b0;
    end else begin
      req_q <= req;
      pend <= p_next;
      overrun <= |(rise & pend & ~clr);
      if (valid && ack) last <= idx;
      if (!valid || ack) begin
        valid <= |p_next;
        if (|p_next) idx <= sel;
      end
    end
  end
endmodule

// File: tb/tb_pri_enc_16_4.sv
// tb_pri_enc_16_4: random and directed checks of both priority modes against a behavioural model
module tb_pri_enc_16_4;
  logic clk = 0, reset, en, ack;
  logic [15:0] req;
  logic [3:0] idx_f, idx_r;
  logic valid_f, valid_r, ov_f, ov_r;
  logic [15:0] pend_f, pend_r;
  int n_chk = 0, n_fail = 0;
  bit started = 0;
  bit mp[2][16];
  bit mv[2], mo[2];
  int mi[2], ml[2];
  bit prev[16];

  always #5 clk = ~clk;

  pri_enc_16_4 #(.RR_EN(1'b0)) dut_f (.clk(clk), .reset(reset), .en(en), .req(req), .ack(ack),
    .idx(idx_f), .valid(valid_f), .pend(pend_f), .overrun(ov_f));
  pri_enc_16_4 #(.RR_EN(1'b1)) dut_r (.clk(clk), .reset(reset), .en(en), .req(req), .ack(ack),
    .idx(idx_r), .valid(valid_r), .pend(pend_r), .overrun(ov_r));

  task automatic chk(input string n, input logic [15:0] a, input logic [15:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
    end
  endtask

  function automatic logic [15:0] mpend(input int m);
    logic [15:0] v = '0;
    for (int b = 0; b < 16; b++) v[b] = mp[m][b];
    return v;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      started = 1;
      for (int m = 0; m < 2; m++) begin
        for (int b = 0; b < 16; b++) mp[m][b] = 0;
        mv[m] = 0; mi[m] = 0; ml[m] = 15; mo[m] = 0;
      end
      for (int b = 0; b < 16; b++) prev[b] = 0;
    end else begin
      for (int m = 0; m < 2; m++) begin
        int g, found;
        bit np[16];
        g = (mv[m] && ack) ? mi[m] : -1;
        mo[m] = 0;
        for (int b = 0; b < 16; b++) begin
          bit r;
          r = req[b] && !prev[b] && en;
          np[b] = (mp[m][b] && b != g) || r;
          if (r && mp[m][b] && b != g) mo[m] = 1;
        end
        mp[m] = np;
        if (g >= 0) ml[m] = g;
        if (!mv[m] || ack) begin
          found = -1;
          if (m == 0) begin
            for (int b = 15; b >= 0 && found < 0; b--) if (np[b]) found = b;
          end else begin
            for (int k = 1; k <= 16 && found < 0; k++) if (np[(ml[m] + k) % 16]) found = (ml[m] + k) % 16;
          end
          mv[m] = found >= 0;
          if (found >= 0) mi[m] = found;
        end
      end
      for (int b = 0; b < 16; b++) prev[b] = req[b];
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("fix_valid", 16'(valid_f), 16'(mv[0]));
      chk("fix_idx", 16'(idx_f), 16'(mi[0]));
      chk("fix_pend", pend_f, mpend(0));
      chk("fix_overrun", 16'(ov_f), 16'(mo[0]));
      chk("rr_valid", 16'(valid_r), 16'(mv[1]));
      chk("rr_idx", 16'(idx_r), 16'(mi[1]));
      chk("rr_pend", pend_r, mpend(1));
      chk("rr_overrun", 16'(ov_r), 16'(mo[1]));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1; req = '0; ack = 0; en = 1;
    cyc();
    reset = 0;
  endtask

  initial begin
    reset = 1; en = 1; ack = 0; req = '0;
    cyc();
    chk("rst_valid", 16'(valid_f), 16'd0);
    chk("rst_idx", 16'(idx_f), 16'd0);
    chk("rst_pend", pend_f, 16'h0);
    reset = 0; req = 16'h0008;
    cyc();
    chk("lat_valid", 16'(valid_f), 16'd1);
    chk("lat_idx", 16'(idx_f), 16'd3);
    chk("lat_pend", pend_f, 16'h0008);
    chk("model_idx", 16'(mi[0]), 16'd3);
    req = '0; ack = 1;
    cyc();
    chk("ack_valid", 16'(valid_f), 16'd0);
    chk("ack_pend", pend_f, 16'h0);
    ack = 0;
    do_reset();
    req = 16'h8421; ack = 1;
    cyc(); chk("fix_seq0", 16'(idx_f), 16'd15);
    cyc(); chk("fix_seq1", 16'(idx_f), 16'd10);
    cyc(); chk("fix_seq2", 16'(idx_f), 16'd5);
    cyc(); chk("fix_seq3", 16'(idx_f), 16'd0);
    chk("fix_seq3_v", 16'(valid_f), 16'd1);
    cyc(); chk("fix_seq_end", 16'(valid_f), 16'd0);
    do_reset();
    req = 16'h0200;
    cyc(); chk("rr_first", 16'(idx_r), 16'd9);
    req = 16'h0204;
    cyc(); chk("rr_hold9", 16'(idx_r), 16'd9);
    chk("rr_pend", pend_r, 16'h0204);
    req = 16'h1206; ack = 1;
    cyc(); chk("rr_g12", 16'(idx_r), 16'd12);
    chk("model_rr12", 16'(mi[1]), 16'd12);
    cyc(); chk("rr_g1", 16'(idx_r), 16'd1);
    cyc(); chk("rr_g2", 16'(idx_r), 16'd2);
    cyc(); chk("rr_empty", 16'(valid_r), 16'd0);
    do_reset();
    req = 16'h0010;
    cyc(); chk("hold_idx4", 16'(idx_f), 16'd4);
    req = 16'h4010;
    cyc(); chk("hold_keep4", 16'(idx_f), 16'd4);
    cyc(); chk("hold_keep4b", 16'(idx_f), 16'd4);
    chk("hold_pend", pend_f, 16'h4010);
    ack = 1;
    cyc(); chk("hold_next14", 16'(idx_f), 16'd14);
    cyc(); chk("hold_done", 16'(valid_f), 16'd0);
    do_reset();
    req = 16'h0040;
    cyc(); chk("ov_idx6", 16'(idx_f), 16'd6);
    req = '0;
    cyc();
    req = 16'h0040;
    cyc(); chk("ov_pulse", 16'(ov_f), 16'd1);
    chk("ov_pend6", pend_f, 16'h0040);
    cyc(); chk("ov_single", 16'(ov_f), 16'd0);
    req = '0;
    cyc();
    req = 16'h0040; ack = 1;
    cyc(); chk("ov_ack_none", 16'(ov_f), 16'd0);
    chk("ov_ack_pend", pend_f, 16'h0040);
    chk("ov_ack_valid", 16'(valid_f), 16'd1);
    ack = 0;
    do_reset();
    en = 0; req = 16'h0080;
    cyc();
    en = 1;
    cyc(); chk("en_pend", pend_f, 16'h0);
    chk("en_valid", 16'(valid_f), 16'd0);
    req = '0;
    cyc();
    req = 16'hFFFF;
    cyc(); chk("full_pend", pend_f, 16'hFFFF);
    reset = 1;
    cyc(); chk("mid_rst_pend", pend_f, 16'h0);
    chk("mid_rst_valid", 16'(valid_f), 16'd0);
    chk("mid_rst_idx", 16'(idx_f), 16'd0);
    chk("mid_rst_ov", 16'(ov_f), 16'd0);
    reset = 0;
    for (int c = 0; c < 3000; c++) begin
      req = req ^ 16'($urandom & $urandom & $urandom);
      en = $urandom_range(0, 7) != 0;
      ack = $urandom_range(0, 2) != 0;
      reset = $urandom_range(0, 199) == 0;
      cyc();
    end
    reset = 0;
    cyc();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
